// File: rtl/am_ctrl_pkg.sv
// am_ctrl_pkg
// Shared definitions for the AM parameter controller:
//   - mode encoding (FREQ / DEPTH / SWEEP) and the mode rotation helper
//   - per-key event FSM state encoding (IDLE / FIRST / HOLD)
//   - default limits and reset values for the phase increment and depth
//   - key index constants and a counter width helper
package am_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_FREQ  = 2'd0,
    MODE_DEPTH = 2'd1,
    MODE_SWEEP = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    KEY_IDLE  = 2'd0,
    KEY_FIRST = 2'd1,
    KEY_HOLD  = 2'd2
  } key_state_t;

  localparam int INC_MIN_DEF    = 1;
  localparam int INC_MAX_DEF    = 1023;
  localparam int INC_RST_DEF    = 16;
  localparam int DEPTH_STEP_DEF = 16;
  localparam int DEPTH_RST_DEF  = 192;

  // Key positions in the debouncer array.
  localparam int KEY_ADD  = 0;
  localparam int KEY_SUB  = 1;
  localparam int KEY_MODE = 2;

  // Width of a counter that runs 0 .. n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // FREQ -> DEPTH -> SWEEP -> FREQ.
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_FREQ:  return MODE_DEPTH;
      MODE_DEPTH: return MODE_SWEEP;
      default:    return MODE_FREQ;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce
// Two-flop synchronizer plus debounce counter for one raw push-button.
// Ports:
//   clk      - system clock
//   rst_n    - active-low reset (asynchronous assert)
//   i_key    - raw, asynchronous key input (active high)
//   o_level  - debounced key level
//   o_rise   - one-cycle pulse on a debounced rise of an armed key
module key_debounce
  import am_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [1:0]    r_fill;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_rise;
  logic          r_armed;
  logic          w_flip;

  assign w_flip  = (r_sync[1] != r_level) && (r_cnt == CNT_LAST);
  assign o_level = r_level;
  assign o_rise  = r_rise;

  // r_fill marks when r_sync holds real samples again after reset. The key
  // is armed only once it has been seen released after that point, so a key
  // held through reset produces no rise until it is let go and pressed again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_fill  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_key};
      r_fill  <= {r_fill[0], 1'b1};
      r_armed <= r_armed | (r_fill[1] & ~r_sync[1]);
      r_rise  <= w_flip & r_sync[1] & r_armed;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/am_param_ctrl.sv
// am_param_ctrl
// Push-button controller for the AM generator parameters.
// Ports:
//   clk            - system clock
//   rst            - asynchronous active-low reset (deassertion synchronized)
//   ctrl_key_add   - raw "add" key, active high
//   ctrl_key_sub   - raw "sub" key, active high
//   ctrl_key_mode  - raw "mode" key, active high
//   addr_change    - carrier DDS phase increment
//   mod_depth      - modulation depth coefficient
//   mode           - 0 FREQ, 1 DEPTH, 2 SWEEP
//   cfg_valid      - one-cycle pulse when any output value changes
module am_param_ctrl
  import am_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES    = 500000,
  parameter int REPEAT_CYCLES = 12500000,
  parameter int SWEEP_DIV     = 50000,
  parameter int INC_MIN       = INC_MIN_DEF,
  parameter int INC_MAX       = INC_MAX_DEF,
  parameter int INC_RST       = INC_RST_DEF,
  parameter int DEPTH_STEP    = DEPTH_STEP_DEF,
  parameter int DEPTH_RST     = DEPTH_RST_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ctrl_key_add,
  input  logic       ctrl_key_sub,
  input  logic       ctrl_key_mode,
  output logic [9:0] addr_change,
  output logic [7:0] mod_depth,
  output logic [1:0] mode,
  output logic       cfg_valid
);

  localparam int RW = cnt_width(REPEAT_CYCLES);
  localparam int SW = cnt_width(SWEEP_DIV);
  localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_CYCLES - 1);
  localparam logic [SW-1:0] SWEEP_LAST = SW'(SWEEP_DIV - 1);
  localparam logic [9:0]    L_INC_MIN  = 10'(INC_MIN);
  localparam logic [9:0]    L_INC_MAX  = 10'(INC_MAX);
  localparam logic [7:0]    L_DSTEP    = 8'(DEPTH_STEP);

  // Reset asserts immediately, releases two clocks later in step with clk.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_sync <= '0;
    else      r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Debouncers: add, sub, mode.
  logic [2:0] w_keys_raw;
  logic [2:0] w_level;
  logic [2:0] w_rise;
  logic [1:0] w_step;
  logic       w_unused_mode_level;

  assign w_keys_raw          = {ctrl_key_mode, ctrl_key_sub, ctrl_key_add};
  assign w_unused_mode_level = w_level[KEY_MODE];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_deb
      key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk     (clk),
        .rst_n   (w_rst_n),
        .i_key   (w_keys_raw[gi]),
        .o_level (w_level[gi]),
        .o_rise  (w_rise[gi])
      );
    end
  endgenerate

  // Event FSMs for add (0) and sub (1): one step on press, then auto-repeat.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fsm
      key_state_t    r_state;
      key_state_t    w_state_next;
      logic [RW-1:0] r_rep_cnt;
      logic [RW-1:0] w_rep_cnt_next;
      logic          w_step_i;

      always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
          r_state   <= KEY_IDLE;
          r_rep_cnt <= '0;
        end else begin
          r_state   <= w_state_next;
          r_rep_cnt <= w_rep_cnt_next;
        end
      end

      always_comb begin
        w_state_next   = r_state;
        w_rep_cnt_next = r_rep_cnt;
        w_step_i       = 1'b0;
        case (r_state)
          KEY_IDLE: begin
            w_rep_cnt_next = '0;
            if (w_rise[gi]) w_state_next = KEY_FIRST;
          end
          KEY_FIRST: begin
            w_step_i       = 1'b1;
            w_rep_cnt_next = '0;
            w_state_next   = w_level[gi] ? KEY_HOLD : KEY_IDLE;
          end
          KEY_HOLD: begin
            if (!w_level[gi]) begin
              w_state_next   = KEY_IDLE;
              w_rep_cnt_next = '0;
            end else if (r_rep_cnt == REP_LAST) begin
              w_step_i       = 1'b1;
              w_rep_cnt_next = '0;
            end else begin
              w_rep_cnt_next = r_rep_cnt + 1'b1;
            end
          end
          default: begin
            w_state_next   = KEY_IDLE;
            w_rep_cnt_next = '0;
          end
        endcase
      end

      assign w_step[gi] = w_step_i;
    end
  endgenerate

  // Parameter registers.
  logic [9:0]    r_addr, w_addr_next;
  logic [7:0]    r_depth, w_depth_next;
  mode_t         r_mode, w_mode_next;
  logic          r_cfg_valid, w_cfg_next;
  logic [SW-1:0] r_sweep_cnt, w_sweep_cnt_next;
  logic          w_add, w_sub;
  logic [8:0]    w_depth_sum;

  // Simultaneous add and sub cancel out.
  assign w_add       = w_step[KEY_ADD] & ~w_step[KEY_SUB];
  assign w_sub       = w_step[KEY_SUB] & ~w_step[KEY_ADD];
  assign w_depth_sum = {1'b0, r_depth} + {1'b0, L_DSTEP};

  always_comb begin
    w_addr_next      = r_addr;
    w_depth_next     = r_depth;
    w_mode_next      = r_mode;
    w_sweep_cnt_next = '0;   // held at zero outside SWEEP, so entry starts clean
    // Steps act under the current mode; a mode change lands afterwards.
    case (r_mode)
      MODE_FREQ: begin
        if (w_add && (r_addr < L_INC_MAX)) w_addr_next = r_addr + 10'd1;
        if (w_sub && (r_addr > L_INC_MIN)) w_addr_next = r_addr - 10'd1;
      end
      MODE_DEPTH: begin
        if (w_add) w_depth_next = (w_depth_sum > 9'd255) ? 8'd255 : w_depth_sum[7:0];
        if (w_sub) w_depth_next = (r_depth < L_DSTEP) ? 8'd0 : (r_depth - L_DSTEP);
      end
      MODE_SWEEP: begin
        if (r_sweep_cnt == SWEEP_LAST) begin
          w_addr_next = (r_addr >= L_INC_MAX) ? L_INC_MIN : (r_addr + 10'd1);
        end else begin
          w_sweep_cnt_next = r_sweep_cnt + 1'b1;
        end
      end
      default: ;
    endcase
    if (w_rise[KEY_MODE]) w_mode_next = next_mode(r_mode);
    w_cfg_next = (w_addr_next != r_addr) || (w_depth_next != r_depth) ||
                 (w_mode_next != r_mode);
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_addr      <= 10'(INC_RST);
      r_depth     <= 8'(DEPTH_RST);
      r_mode      <= MODE_FREQ;
      r_cfg_valid <= 1'b0;
      r_sweep_cnt <= '0;
    end else begin
      r_addr      <= w_addr_next;
      r_depth     <= w_depth_next;
      r_mode      <= w_mode_next;
      r_cfg_valid <= w_cfg_next;
      r_sweep_cnt <= w_sweep_cnt_next;
    end
  end

  assign addr_change = r_addr;
  assign mod_depth   = r_depth;
  assign mode        = r_mode;
  assign cfg_valid   = r_cfg_valid;

endmodule

// File: doc/am_param_ctrl.md
AM_PARAM_CTRL -- requirements
Module: am_param_ctrl

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 500000, meaning key stability time in clk cycles (10 ms at 50 MHz).
REQ-002 The block SHALL have parameter REPEAT_CYCLES, default 12500000, meaning the auto-repeat period while a key is held.
REQ-003 The block SHALL have parameter SWEEP_DIV, default 50000, meaning clk cycles per sweep step.
REQ-004 The block SHALL have parameters INC_MIN 1, INC_MAX 1023, INC_RST 16, DEPTH_STEP 16, DEPTH_RST 192, meaning phase-increment limits, phase-increment reset value, depth step and depth reset value.
REQ-005 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have ports ctrl_key_add, ctrl_key_sub and ctrl_key_mode, each input, 1 bit: raw asynchronous push-buttons, active-high when pressed.
REQ-008 The block SHALL have port addr_change, output, 10 bits: carrier DDS phase increment.
REQ-009 The block SHALL have port mod_depth, output, 8 bits: unsigned modulation-depth coefficient for the multiplier.
REQ-010 The block SHALL have port mode, output, 2 bits: 0 FREQ, 1 DEPTH, 2 SWEEP.
REQ-011 The block SHALL have port cfg_valid, output, 1 bit: one-cycle pulse on any change of addr_change, mod_depth or mode.

Function
REQ-012 Each key SHALL be passed through a 2-FF synchronizer, then debounced: the debounced level changes only after the synchronized input has differed from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-013 Per add/sub key, an event FSM SHALL use states IDLE, FIRST, HOLD. On a debounced rise: IDLE->FIRST, which issues one step and goes to HOLD. In HOLD, one step is issued every REPEAT_CYCLES while the key is held. On a debounced fall: ->IDLE.
REQ-014 The mode key SHALL NOT auto-repeat; each debounced rise advances mode FREQ->DEPTH->SWEEP->FREQ.
REQ-015 In FREQ, an add step SHALL set addr_change += 1 and a sub step addr_change -= 1, both saturating at INC_MAX and INC_MIN.
REQ-016 In DEPTH, steps SHALL change mod_depth by ±DEPTH_STEP, saturating at 255 and 0.
REQ-017 In SWEEP, add/sub steps SHALL be ignored; a SWEEP_DIV counter SHALL increment addr_change by 1 each period, and addr_change SHALL wrap from INC_MAX to INC_MIN.
REQ-018 On entering SWEEP the sweep counter SHALL clear; on leaving SWEEP, addr_change SHALL keep its current value.
REQ-019 Add and sub steps falling in the same cycle SHALL cancel, leaving no change and no cfg_valid.
REQ-020 A mode change and a step in the same cycle: the step SHALL be applied under the old mode, then the mode SHALL update.
REQ-021 Outputs SHALL be registered, with one-cycle latency from the step event to the new value; cfg_valid SHALL assert in the same cycle the new value appears.
REQ-022 A saturated step that produces no value change SHALL NOT pulse cfg_valid.

Reset
REQ-023 While rst=0, the block SHALL asynchronously force: addr_change=INC_RST, mod_depth=DEPTH_RST, mode=FREQ, cfg_valid=0, all FSMs IDLE, all counters 0, synchronizers and debounced levels 0.
REQ-024 Reset SHALL take effect mid-press or mid-sweep with no step issued afterwards until a fresh debounced rise occurs.
REQ-025 Reset release SHALL be synchronized to clk, with 2-FF deassertion.

Structure
REQ-026 Shared package am_ctrl_pkg SHALL hold the mode encoding (FREQ/DEPTH/SWEEP), the key-FSM state encoding, and the INC_* / DEPTH_* default constants.
REQ-027 Sub-module key_debounce SHALL contain the synchronizer, debounce counter and debounced level, parameterized by DEB_CYCLES, and SHALL be instantiated three times.

Verification (DEB_CYCLES=4, REPEAT_CYCLES=16, SWEEP_DIV=8)
REQ-028 A bench SHALL check: reset, then add held 3 cycles and released -> no change; add held 6 cycles -> addr_change 16->17, exactly one cfg_valid.
REQ-029 A bench SHALL check: add held 60 cycles after debounce -> addr_change 17 at first step, then +1 every 16 cycles (17,18,19,20); it stops on release.
REQ-030 A bench SHALL check: mode->DEPTH, then sub pressed 13 times -> mod_depth 192,176,...,0, where the last press gives no change and no cfg_valid.
REQ-031 A bench SHALL check: mode->SWEEP with addr_change forced near 1022 -> values 1022,1023,1,2 spaced 8 cycles; add/sub presses ignored.
REQ-032 A bench SHALL check: add and sub pressed simultaneously in FREQ -> addr_change unchanged and cfg_valid stays 0.
REQ-033 A bench SHALL check: rst low mid-HOLD and mid-SWEEP -> immediately addr_change=16, mod_depth=192, mode=0; with the key still held after release, no step occurs until release and a re-press.
